wave_gen_dds: RTL

- Direct-digital-synthesis waveform generator. It is the consumer of the 3-bit waveform select code produced by the key-driven wave-selection counter in the signal-generator path.
- Converts a phase-increment word plus the select code into an 8-bit unsigned sample stream for the DAC interface.
- Select changes take effect only at a phase wrap, so the output never shows a partial-period glitch.

---
 rtl/wave_gen_dds.sv | 108 ++++++++++
 1 files changed

// File: rtl/wave_gen_dds.sv
// rtl/wave_gen_dds.sv - DDS waveform generator: phase accumulator, wrap-aligned select latch,
// and a fixed two-stage pipeline from phase to an 8-bit unsigned sample.
module wave_gen_dds #(
  parameter int         ACC_W = 32,
  parameter logic [7:0] MID   = 8'd128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [ACC_W-1:0] freq_word,
  input  logic [2:0]       wave_sel,
  output logic [7:0]       dout,
  output logic             wrap_pulse,
  output logic [2:0]       sel_active
);

  // Quarter-wave sine magnitude, round(127.5*sin(2*pi*(k+0.5)/256)).
  function automatic logic [6:0] quarter_sine(input logic [5:0] k);
    logic [6:0] q;
    case (k)
      6'd0:  q = 7'd2;    6'd1:  q = 7'd5;    6'd2:  q = 7'd8;    6'd3:  q = 7'd11;
      6'd4:  q = 7'd14;   6'd5:  q = 7'd17;   6'd6:  q = 7'd20;   6'd7:  q = 7'd23;
      6'd8:  q = 7'd26;   6'd9:  q = 7'd29;   6'd10: q = 7'd32;   6'd11: q = 7'd36;
      6'd12: q = 7'd39;   6'd13: q = 7'd41;   6'd14: q = 7'd44;   6'd15: q = 7'd47;
      6'd16: q = 7'd50;   6'd17: q = 7'd53;   6'd18: q = 7'd56;   6'd19: q = 7'd59;
      6'd20: q = 7'd61;   6'd21: q = 7'd64;   6'd22: q = 7'd67;   6'd23: q = 7'd70;
      6'd24: q = 7'd72;   6'd25: q = 7'd75;   6'd26: q = 7'd77;   6'd27: q = 7'd80;
      6'd28: q = 7'd82;   6'd29: q = 7'd84;   6'd30: q = 7'd87;   6'd31: q = 7'd89;
      6'd32: q = 7'd91;   6'd33: q = 7'd93;   6'd34: q = 7'd96;   6'd35: q = 7'd98;
      6'd36: q = 7'd100;  6'd37: q = 7'd101;  6'd38: q = 7'd103;  6'd39: q = 7'd105;
      6'd40: q = 7'd107;  6'd41: q = 7'd109;  6'd42: q = 7'd110;  6'd43: q = 7'd112;
      6'd44: q = 7'd113;  6'd45: q = 7'd115;  6'd46: q = 7'd116;  6'd47: q = 7'd117;
      6'd48: q = 7'd118;  6'd49: q = 7'd120;  6'd50: q = 7'd121;  6'd51: q = 7'd122;
      6'd52: q = 7'd122;  6'd53: q = 7'd123;  6'd54: q = 7'd124;  6'd55: q = 7'd125;
      6'd56: q = 7'd125;  6'd57: q = 7'd126;  6'd58: q = 7'd126;  6'd59: q = 7'd127;
      6'd60: q = 7'd127;  6'd61: q = 7'd127;  6'd62: q = 7'd127;
      default: q = 7'd127;
    endcase
    return q;
  endfunction

  function automatic logic [7:0] wave_fn(input logic [2:0] sel, input logic [7:0] p);
    logic [7:0] tri_up;
    logic [6:0] q;
    tri_up = {p[6:0], 1'b0};
    // Odd quadrants run the table backwards; 63-i equals ~i in six bits.
    q = quarter_sine(p[6] ? ~p[5:0] : p[5:0]);
    case (sel)
      3'd0:    wave_fn = p[7] ? (8'd127 - {1'b0, q}) : (8'd128 + {1'b0, q});
      3'd1:    wave_fn = p[7] ? (8'd255 - tri_up) : tri_up;
      3'd2:    wave_fn = p;
      3'd3:    wave_fn = p[7] ? 8'd0 : 8'd255;
      default: wave_fn = MID;
    endcase
  endfunction

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             acc_wrap_q, acc_wrap_d;
  logic [2:0]       sel_active_q, sel_active_d;
  logic [7:0]       p_q, p_d;
  logic [2:0]       sel_q, sel_d;
  logic             wrap_q, wrap_d;
  logic [7:0]       dout_q, dout_d;
  logic             wrap_pulse_q, wrap_pulse_d;
  logic [ACC_W:0]   sum;
  logic             wrap;

  always_comb begin
    sum          = {1'b0, acc_q} + {1'b0, freq_word};
    wrap         = en & sum[ACC_W];
    acc_d        = en ? sum[ACC_W-1:0] : acc_q;
    acc_wrap_d   = wrap;
    // A stopped or zero-rate accumulator has no period to protect, so follow the request directly.
    sel_active_d = (wrap || !en || freq_word == '0) ? wave_sel : sel_active_q;
    p_d          = acc_q[ACC_W-1 -: 8];
    sel_d        = sel_active_q;
    wrap_d       = acc_wrap_q;
    dout_d       = wave_fn(sel_q, p_q);
    wrap_pulse_d = wrap_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q        <= '0;
      acc_wrap_q   <= 1'b0;
      sel_active_q <= 3'd0;
      p_q          <= 8'd0;
      sel_q        <= 3'd0;
      wrap_q       <= 1'b0;
      dout_q       <= MID;
      wrap_pulse_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      acc_wrap_q   <= acc_wrap_d;
      sel_active_q <= sel_active_d;
      p_q          <= p_d;
      sel_q        <= sel_d;
      wrap_q       <= wrap_d;
      dout_q       <= dout_d;
      wrap_pulse_q <= wrap_pulse_d;
    end
  end

  assign dout       = dout_q;
  assign wrap_pulse = wrap_pulse_q;
  assign sel_active = sel_active_q;

endmodule
